// File: rtl/link_tx_scheduler.sv
// Round-robin scheduler that grants one packet source at a time and streams its
// latched packet as SYNC, ID, payload bytes, CHK over a valid/ready byte port.
module link_tx_scheduler #(
  parameter int          N_REQ     = 3,
  parameter int          PKT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*PKT_BYTES*8-1:0] pkt_data,
  output logic [N_REQ-1:0]             grant,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PB = PKT_BYTES * 8;
  localparam logic [3:0] LAST = 4'(PKT_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_PAY, S_CHK} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PB-1:0]    pay_q, pay_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       id_q, id_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             found;
  logic [PW-1:0]    sel;
  int               nxt;
  logic [3:0]       nidx;
  logic [7:0]       byte_nxt;
  logic             hs;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        found = 1'b1;
        sel   = PW'(j);
      end
    end
    nxt = int'(sel) + 1;
    if (nxt >= N_REQ) nxt = 0;
  end

  assign hs       = tx_valid_q & tx_ready;
  assign nidx     = (cnt_q == LAST) ? cnt_q : cnt_q + 4'd1;
  assign byte_nxt = pay_q[int'(nidx)*8 +: 8];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    chk_d      = chk_q;
    id_d       = id_q;
    grant_d    = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (found) begin
          grant_d[sel] = 1'b1;
          ptr_d        = PW'(nxt);
          pay_d        = pkt_data[int'(sel)*PB +: PB];
          id_d         = 8'(sel);
          chk_d        = 8'(sel);
          tx_data_d    = SYNC_BYTE;
          tx_valid_d   = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_SYNC;
        end
      end
      S_SYNC: if (hs) begin
        tx_data_d = id_q;
        state_d   = S_ID;
      end
      S_ID: if (hs) begin
        tx_data_d = pay_q[7:0];
        chk_d     = chk_q + pay_q[7:0];
        cnt_d     = 4'd0;
        state_d   = S_PAY;
      end
      S_PAY: if (hs) begin
        if (cnt_q == LAST) begin
          // chk_q already holds ID plus every payload byte.
          tx_data_d = chk_q;
          state_d   = S_CHK;
        end else begin
          cnt_d     = nidx;
          tx_data_d = byte_nxt;
          chk_d     = chk_q + byte_nxt;
        end
      end
      S_CHK: if (hs) begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      pay_q      <= '0;
      chk_q      <= '0;
      id_q       <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      chk_q      <= chk_d;
      id_q       <= id_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler: frame contents, backpressure, fairness,
// checksum wrap, mid-frame reset and withdrawn requests.
module tb_link_tx_scheduler;
  localparam int N = 3;
  localparam int P = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*P*8-1:0] pkt_data = '0;
  logic             tx_ready = 1'b1;
  logic [N-1:0]     grant;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  link_tx_scheduler #(.N_REQ(N), .PKT_BYTES(P), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .req(req), .pkt_data(pkt_data), .grant(grant),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];
  logic [N-1:0] gnt_q[$];
  int           gnt_t[$];

  // Inputs only change at posedge+1, so negedge sees settled handshake inputs.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_valid && tx_ready) acc_q.push_back(tx_data);
      if (grant != '0) begin
        gnt_q.push_back(grant);
        gnt_t.push_back(cyc);
      end
      if (done) done_cnt++;
      if (done && grant != '0) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [31:0] v);
    pkt_data[i*32 +: 32] = v;
  endtask

  function automatic void push_frame(input int id, input logic [31:0] pl);
    logic [7:0] s;
    s = 8'(id);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(id));
    for (int b = 0; b < P; b++) begin
      exp_q.push_back(pl[b*8 +: 8]);
      s = s + pl[b*8 +: 8];
    end
    exp_q.push_back(s);
  endfunction

  task automatic clear_logs();
    acc_q.delete();
    exp_q.delete();
    gnt_q.delete();
    gnt_t.delete();
  endtask

  task automatic wait_done(input string tag);
    int start;
    bit ok;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic wait_grants(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gnt_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_grant_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size())
        check($sformatf("%s_b%0d", tag, i), 32'(acc_q[i]), 32'(exp_q[i]));
    end
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int dstart;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_grant", 32'(grant), 32'd0);
    check("rst_in_valid", 32'(tx_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Single frame from requester 1 with grant latency
    set_slice(1, 32'h04030201);
    tick();
    req = 3'b010;
    @(negedge clk);
    check("t1_no_grant_yet", 32'(grant), 32'd0);
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'b010);
    check("t1_valid", 32'(tx_valid), 32'd1);
    check("t1_sync", 32'(tx_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    req = 3'b000;
    wait_done("t1");
    exp_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    check_stream("t1");
    check("t1_grant_count", 32'(gnt_q.size()), 32'd1);
    clear_logs();

    // Backpressure on the ID byte
    tx_ready = 1'b0;
    set_slice(1, 32'h10203040);
    req = 3'b010;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_grant_seen", 32'(ok), 32'd1);
    check("t2_sync_held", 32'(tx_data), 32'hA5);
    tick();
    req = 3'b000;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2_stall_data%0d", i), 32'(tx_data), 32'h01);
      check($sformatf("t2_stall_valid%0d", i), 32'(tx_valid), 32'd1);
    end
    tick();
    tx_ready = 1'b1;
    wait_done("t2");
    exp_q = '{8'hA5, 8'h01, 8'h40, 8'h30, 8'h20, 8'h10, 8'hA1};
    check_stream("t2");
    clear_logs();

    // Fairness with all requesters held, then 3'b101
    do_reset();
    set_slice(0, 32'h0D0C0B0A);
    set_slice(1, 32'h1D1C1B1A);
    set_slice(2, 32'h2D2C2B2A);
    dstart = done_cnt;
    req = 3'b111;
    wait_grants(4, "t3_four");
    req = 3'b101;
    wait_grants(5, "t3_five");
    req = 3'b000;
    wait_done("t3");
    check("t3_grant_count", 32'(gnt_q.size()), 32'd5);
    if (gnt_q.size() == 5) begin
      check("t3_g0", 32'(gnt_q[0]), 32'b001);
      check("t3_g1", 32'(gnt_q[1]), 32'b010);
      check("t3_g2", 32'(gnt_q[2]), 32'b100);
      check("t3_g3", 32'(gnt_q[3]), 32'b001);
      check("t3_g4", 32'(gnt_q[4]), 32'b100);
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_gap%0d", i), 32'(gnt_t[i+1] - gnt_t[i]), 32'd8);
    end
    check("t3_done_count", 32'(done_cnt - dstart), 32'd5);
    push_frame(0, 32'h0D0C0B0A);
    push_frame(1, 32'h1D1C1B1A);
    push_frame(2, 32'h2D2C2B2A);
    push_frame(0, 32'h0D0C0B0A);
    push_frame(2, 32'h2D2C2B2A);
    check_stream("t3");
    clear_logs();

    // Checksum wrap
    set_slice(2, 32'hFFFFFFFF);
    req = 3'b100;
    wait_grants(1, "t4");
    req = 3'b000;
    wait_done("t4");
    check("t4_grant", 32'(gnt_q[0]), 32'b100);
    exp_q = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    check_stream("t4");
    clear_logs();

    // Reset during payload byte 2
    set_slice(1, 32'h44332211);
    req = 3'b010;
    wait_grants(1, "t5a");
    req = 3'b000;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'h33) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_byte2_seen", 32'(ok), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_data", 32'(tx_data), 32'd0);
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
    set_slice(0, 32'hC0B0A090);
    req = 3'b111;
    wait_grants(1, "t5b");
    req = 3'b000;
    check("t5_ptr_reset", 32'(gnt_q[0]), 32'b001);
    wait_done("t5b");
    push_frame(0, 32'hC0B0A090);
    req = 3'b010;
    wait_grants(2, "t5c");
    req = 3'b000;
    wait_done("t5c");
    check("t5_fresh_grant", 32'(gnt_q[1]), 32'b010);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'hAB);
    check_stream("t5");
    clear_logs();

    // Request 0 raised and withdrawn while requester 1's frame is on the wire
    req = 3'b010;
    wait_grants(1, "t6");
    req = 3'b000;
    repeat (2) tick();
    req = 3'b001;
    repeat (2) tick();
    req = 3'b000;
    wait_done("t6");
    repeat (5) tick();
    check("t6_grant_count", 32'(gnt_q.size()), 32'd1);
    check("t6_grant", 32'(gnt_q[0]), 32'b010);
    push_frame(1, 32'h44332211);
    check_stream("t6");

    check("no_done_grant_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
